flash_cache: RTL and testbench

- Direct-mapped, read-only word cache between the CPU memory bus and the SPI flash controller.
- Hits are served in 2 cycles. Misses issue one 32-bit read on the flash controller's memory-bus interface and fill the line.
- Same bus protocol on both sides: the master holds sel/address stable until a single-cycle ready pulse.
- Writes to the flash region are acknowledged and discarded.

---
 rtl/flash_cache_if.sv | 21 ++
 rtl/flash_cache.sv | 158 +++++++++++++++
 tb/tb_flash_cache.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_cache_if.sv
// flash_cache_if: word bus used on both sides of the flash cache.
// master drives address/sel/read/write_*; slave returns read_value/ready.
interface flash_cache_if;
  logic [31:0] address;
  logic        sel;
  logic        read;
  logic [31:0] read_value;
  logic [3:0]  write_mask;
  logic [31:0] write_value;
  logic        ready;

  modport master (
    output address, sel, read, write_mask, write_value,
    input  read_value, ready
  );

  modport slave (
    input  address, sel, read, write_mask, write_value,
    output read_value, ready
  );
endinterface

// File: rtl/flash_cache.sv
// flash_cache: direct-mapped read-only word cache in front of SPI flash.
// Ports: clk, reset (sync, active-high), flush_in (invalidate all),
//   cpu   (slave):  address_in/sel_in/read_in/write_* in, read_value/ready out
//   flash (master): flash_address/sel/read out, read_value/ready in
module flash_cache #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_BITS  = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_in,
  flash_cache_if.slave  cpu,
  flash_cache_if.master flash
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FILL,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [31:0]          data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 fsel_q, fsel_d;
  logic                 fread_q, fread_d;
  logic                 flush_pend_q, flush_pend_d;

  logic [31:0]          data_ram [LINES];
  logic [TAG_BITS-1:0]  tag_ram  [LINES];
  logic [31:0]          ram_data_q;
  logic [TAG_BITS-1:0]  ram_tag_q;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  ram_re;
  logic                  ram_we;
  logic                  hit;
  logic                  unused_bits;

  // Address is never registered: the master holds it until ready.
  assign index = cpu.address[INDEX_BITS+1:2];
  assign tag   = cpu.address[ADDR_BITS-1:INDEX_BITS+2];

  assign hit = valid_q[index] && (ram_tag_q == tag) && !flush_in;

  // A reset landing on the flash completion must not commit the line.
  assign ram_we = (state_q == FILL) && flash.ready && !reset;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    data_d       = data_q;
    ready_d      = 1'b0;
    fsel_d       = fsel_q;
    fread_d      = fread_q;
    flush_pend_d = 1'b0;
    ram_re       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu.sel && cpu.read) begin
          ram_re  = 1'b1;
          state_d = LOOKUP;
        end else if (cpu.sel && |cpu.write_mask) begin
          data_d  = '0;
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      LOOKUP: begin
        if (hit) begin
          data_d  = ram_data_q;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          fsel_d  = 1'b1;
          fread_d = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        // Any flush seen during the fill keeps this line invalid.
        flush_pend_d = flush_pend_q | flush_in;
        if (flash.ready) begin
          data_d  = flash.read_value;
          fsel_d  = 1'b0;
          fread_d = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
          if (!flush_pend_q && !flush_in) begin
            valid_d[index] = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush_in) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      fsel_q       <= 1'b0;
      fread_q      <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      fsel_q       <= fsel_d;
      fread_q      <= fread_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      data_ram[index] <= flash.read_value;
      tag_ram[index]  <= tag;
    end
    if (ram_re) begin
      ram_data_q <= data_ram[index];
      ram_tag_q  <= tag_ram[index];
    end
  end

  assign cpu.read_value = cpu.sel ? data_q : 32'h0;
  assign cpu.ready      = ready_q;

  assign flash.address     = {{(32-ADDR_BITS){1'b0}},
                              cpu.address[ADDR_BITS-1:2], 2'b00};
  assign flash.sel         = fsel_q;
  assign flash.read        = fread_q;
  assign flash.write_mask  = 4'h0;
  assign flash.write_value = 32'h0;

  // Write data and out-of-region address bits are intentionally ignored.
  assign unused_bits = ^{cpu.write_value,
                         cpu.address[31:ADDR_BITS],
                         cpu.address[1:0]};

endmodule

// File: tb/tb_flash_cache.sv
// tb_flash_cache: scoreboard bench for flash_cache with a flash model.
// Driver pushes expectations; a negedge monitor checks each ready pulse.
module tb_flash_cache;

  localparam int K_HIT   = 0;
  localparam int K_MISS  = 1;
  localparam int K_WRITE = 2;

  typedef struct {
    logic [31:0] data;
    logic [31:0] faddr;
    int          kind;
    int          req_cyc;
    int          req_cnt0;
  } exp_t;

  logic clk;
  logic reset;
  logic flush_in;

  flash_cache_if cpu_if ();
  flash_cache_if fl_if ();

  flash_cache dut (
    .clk      (clk),
    .reset    (reset),
    .flush_in (flush_in),
    .cpu      (cpu_if),
    .flash    (fl_if)
  );

  exp_t        sbq[$];
  int          applied = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          req_cnt = 0;
  int          fr_cyc = -10;
  int          fdelay = 4;
  logic [31:0] last_addr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    applied++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] fmem(input logic [31:0] a);
    case (a)
      32'h0000_0100: fmem = 32'hDEAD_BEEF;
      32'h0000_0200: fmem = 32'hCAFE_F00D;
      32'h0000_0004: fmem = 32'h0123_4567;
      32'h0000_0008: fmem = 32'h89AB_CDEF;
      32'h0000_000C: fmem = 32'h1357_9BDF;
      32'h0000_0010: fmem = 32'h0BAD_F00D;
      default:       fmem = 32'h0;
    endcase
  endfunction

  // Flash controller model: one request per sel rise, ready after
  // fdelay cycles; a dropped sel abandons the request.
  initial begin
    int st;
    int cd;
    st = 0;
    cd = 0;
    fl_if.ready      = 1'b0;
    fl_if.read_value = '0;
    forever begin
      @(negedge clk);
      fl_if.ready      = 1'b0;
      fl_if.read_value = '0;
      if (!(fl_if.sel && fl_if.read)) begin
        st = 0;
      end else if (st == 0) begin
        req_cnt++;
        last_addr = fl_if.address;
        cd = fdelay;
        st = 1;
      end else if (st == 1) begin
        if (cd > 1) begin
          cd--;
        end else begin
          fl_if.ready      = 1'b1;
          fl_if.read_value = fmem(last_addr);
          fr_cyc = cyc;
          st = 2;
        end
      end
    end
  end

  // Monitor: every ready pulse is matched to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_if.ready === 1'b1) begin
        if (sbq.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL spurious_ready: got 1 want 0 (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("rdata", cpu_if.read_value, e.data);
          chk("fsel_at_ready", {31'b0, fl_if.sel}, 32'h0);
          chk("flash_reqs", req_cnt - e.req_cnt0,
              (e.kind == K_MISS) ? 32'd1 : 32'd0);
          case (e.kind)
            K_HIT:   chk("hit_latency", cyc, e.req_cyc + 2);
            K_WRITE: chk("write_latency", cyc, e.req_cyc + 1);
            default: begin
              chk("miss_latency", cyc, fr_cyc + 1);
              chk("flash_addr", last_addr, e.faddr);
            end
          endcase
        end
      end
    end
  end

  // Called just after a posedge with the DUT idle.
  task automatic issue(input logic [31:0] addr, input bit rd,
                       input int kind, input logic [31:0] want,
                       input int dly);
    exp_t e;
    fdelay     = dly;
    e.data     = want;
    e.faddr    = addr & 32'h00FF_FFFC;
    e.kind     = kind;
    e.req_cyc  = cyc;
    e.req_cnt0 = req_cnt;
    sbq.push_back(e);
    cpu_if.address     = addr;
    cpu_if.sel         = 1'b1;
    cpu_if.read        = rd;
    cpu_if.write_mask  = rd ? 4'h0 : 4'hF;
    cpu_if.write_value = 32'h5555_AAAA;
  endtask

  task automatic finish_txn();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cpu_if.ready !== 1'b1 && n < 300);
    if (cpu_if.ready !== 1'b1) begin
      applied++;
      miscompares++;
      $display("FAIL ready_timeout: got 0 want 1 (cycle %0d)", cyc);
      sbq.delete();
    end
    @(posedge clk);
    #1;
    cpu_if.sel        = 1'b0;
    cpu_if.read       = 1'b0;
    cpu_if.write_mask = 4'h0;
    @(negedge clk);
    chk("rdata_desel", cpu_if.read_value, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [31:0] addr, input bit rd,
                     input int kind, input logic [31:0] want,
                     input int dly);
    issue(addr, rd, kind, want, dly);
    finish_txn();
  endtask

  task automatic pulse_flush();
    flush_in = 1'b1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    flush_in           = 1'b0;
    cpu_if.address     = '0;
    cpu_if.sel         = 1'b0;
    cpu_if.read        = 1'b0;
    cpu_if.write_mask  = '0;
    cpu_if.write_value = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, cpu_if.ready}, 32'h0);
    chk("rst_fsel", {31'b0, fl_if.sel}, 32'h0);
    chk("rst_fread", {31'b0, fl_if.read}, 32'h0);
    chk("rst_rdata", cpu_if.read_value, 32'h0);
    chk("rst_fwmask", {28'b0, fl_if.write_mask}, 32'h0);
    chk("rst_fwval", fl_if.write_value, 32'h0);
    @(posedge clk);
    #1;

    // Cold miss, then hit, then conflict eviction on index 0.
    txn(32'h0000_0100, 1'b1, K_MISS, 32'hDEAD_BEEF, 66);
    txn(32'h0000_0100, 1'b1, K_HIT,  32'hDEAD_BEEF, 4);
    txn(32'h0000_0200, 1'b1, K_MISS, 32'hCAFE_F00D, 5);
    txn(32'h0000_0100, 1'b1, K_MISS, 32'hDEAD_BEEF, 3);
    txn(32'hAB00_0101, 1'b1, K_HIT,  32'hDEAD_BEEF, 4);

    // Flush between transactions.
    txn(32'h0000_0004, 1'b1, K_MISS, 32'h0123_4567, 2);
    txn(32'h0000_0004, 1'b1, K_HIT,  32'h0123_4567, 2);
    pulse_flush();
    txn(32'h0000_0004, 1'b1, K_MISS, 32'h0123_4567, 1);
    txn(32'h0000_0004, 1'b1, K_HIT,  32'h0123_4567, 1);

    // Flush during a fill: data returned, line stays invalid.
    issue(32'h0000_0010, 1'b1, K_MISS, 32'h0BAD_F00D, 20);
    repeat (6) @(posedge clk);
    #1;
    pulse_flush();
    finish_txn();
    txn(32'h0000_0010, 1'b1, K_MISS, 32'h0BAD_F00D, 3);
    txn(32'h0000_0010, 1'b1, K_HIT,  32'h0BAD_F00D, 3);

    // Write is acknowledged next cycle and not cached.
    txn(32'h0000_0008, 1'b0, K_WRITE, 32'h0, 4);
    txn(32'h0000_0008, 1'b1, K_MISS,  32'h89AB_CDEF, 4);

    // Reset in the middle of a fill.
    fdelay         = 40;
    cpu_if.address = 32'h0000_000C;
    cpu_if.sel     = 1'b1;
    cpu_if.read    = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset       = 1'b1;
    cpu_if.sel  = 1'b0;
    cpu_if.read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midfill_rst_fsel", {31'b0, fl_if.sel}, 32'h0);
    chk("midfill_rst_fread", {31'b0, fl_if.read}, 32'h0);
    chk("midfill_rst_ready", {31'b0, cpu_if.ready}, 32'h0);
    repeat (45) @(posedge clk);
    #1;
    txn(32'h0000_000C, 1'b1, K_MISS, 32'h1357_9BDF, 6);
    txn(32'h0000_000C, 1'b1, K_HIT,  32'h1357_9BDF, 6);
    txn(32'h0000_0100, 1'b1, K_MISS, 32'hDEAD_BEEF, 2);

    repeat (5) @(posedge clk);
    chk("sb_drained", sbq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
